// File: rtl/clk_out_seq_pkg.sv
// clk_out_seq_pkg: state encoding and default sizing for the clock-output sequencer
package clk_out_seq_pkg;
    localparam int DIV_W_DEF = 16;
    localparam int SETTLE_CYCLES_DEF = 1024;
    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        IDLE,
        RUN,
        STOP,
        FAULT
    } state_t;
endpackage

// File: rtl/clk_div_gen.sv
// clk_div_gen: phase counter and level register producing the ODDR2 D0/D1 pattern.
// div is the ratio in effect this cycle; div_nxt is the ratio that applies next cycle.
module clk_div_gen
    import clk_out_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] div_nxt,
    output logic             d0,
    output logic             d1,
    output logic             boundary
);
    logic [DIV_W-1:0] cnt;
    logic lvl, wrap, lvl_n;
    // boundary is the last low-phase cycle, or every cycle in passthrough
    always_comb begin
        wrap = cnt == div - DIV_W'(1);
        boundary = div == '0 || (!lvl && wrap);
        lvl_n = (restart || boundary) ? 1'b1 : wrap ? ~lvl : lvl;
    end
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
            lvl <= 1'b0;
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            cnt <= (restart || boundary || wrap) ? '0 : cnt + DIV_W'(1);
            lvl <= lvl_n;
            d0 <= lvl_n;
            d1 <= lvl_n && div_nxt != '0;
        end
    end
endmodule

// File: rtl/clk_out_seq.sv
// clk_out_seq: lock-settle sequencer driving ODDR2 D0/D1 with full-rate or divided clock.
// Define CLK_OUT_SEQ_AUTORESTART_EN to return to WAIT_LOCK on lock loss instead of FAULT.
module clk_out_seq
    import clk_out_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_load,
    output logic             oddr_d0,
    output logic             oddr_d1,
    output logic             ready,
    output logic             running,
    output logic             upd_pending,
    output logic             lock_lost
);
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
`ifdef CLK_OUT_SEQ_AUTORESTART_EN
    localparam state_t LOSS_STATE = WAIT_LOCK;
`else
    localparam state_t LOSS_STATE = FAULT;
`endif
    state_t state, state_n;
    logic [SC_W-1:0] scnt;
    logic [DIV_W-1:0] div_active, div_pend, div_nxt;
    logic boundary, apply, settled, toggling, lock_drop, run_n;
    always_comb begin
        toggling = state == RUN || state == STOP;
        apply = upd_pending && (state inside {WAIT_LOCK, SETTLE, IDLE} || (toggling && boundary));
        div_nxt = apply ? div_pend : div_active;
        settled = scnt == SC_W'(SETTLE_CYCLES - 1);
        lock_drop = !lock && state inside {IDLE, RUN, STOP};
        case (state)
            WAIT_LOCK: state_n = lock ? SETTLE : WAIT_LOCK;
            SETTLE:    state_n = !lock ? WAIT_LOCK : settled ? IDLE : SETTLE;
            IDLE:      state_n = cfg_en ? RUN : IDLE;
            RUN:       state_n = cfg_en ? RUN : boundary ? IDLE : STOP;
            STOP:      state_n = boundary ? IDLE : STOP;
            FAULT:     state_n = cfg_en ? FAULT : WAIT_LOCK;
            default:   state_n = WAIT_LOCK;
        endcase
        if (lock_drop) state_n = LOSS_STATE;
        run_n = state_n == RUN || state_n == STOP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOCK;
            scnt <= '0;
            div_active <= '0;
            div_pend <= '0;
            upd_pending <= 1'b0;
            lock_lost <= 1'b0;
            ready <= 1'b0;
            running <= 1'b0;
        end else begin
            state <= state_n;
            scnt <= (state == SETTLE && state_n == SETTLE) ? scnt + SC_W'(1) : '0;
            div_active <= div_nxt;
            if (cfg_load) div_pend <= cfg_div;
            upd_pending <= cfg_load || (upd_pending && !apply);
            lock_lost <= lock_drop || (lock_lost && !(state == IDLE && state_n == RUN));
            ready <= state_n inside {IDLE, RUN, STOP};
            running <= run_n;
        end
    end
    clk_div_gen #(.DIV_W(DIV_W)) u_gen (
        .clk(clk),
        .rst(rst),
        .run(run_n),
        .restart(state == IDLE),
        .div(div_active),
        .div_nxt(div_nxt),
        .d0(oddr_d0),
        .d1(oddr_d1),
        .boundary(boundary)
    );
endmodule

// File: tb/tb_clk_out_seq.sv
// tb_clk_out_seq: directed plus random stimulus checked cycle by cycle against a waveform-position model
module tb_clk_out_seq;
    localparam int DW = 4;
    localparam int SC = 20;
    localparam int M_WAIT = 0, M_SETTLE = 1, M_IDLE = 2, M_RUN = 3, M_STOP = 4, M_FAULT = 5;
    logic clk = 1'b0;
    logic rst, lock, cfg_en, cfg_load;
    logic [DW-1:0] cfg_div;
    logic oddr_d0, oddr_d1, ready, running, upd_pending, lock_lost;
    int vectors = 0, miscompares = 0;
    int m_st, m_sc, m_nact, m_npend, m_pos;
    bit m_pend, m_lost, r_en;
    logic [5:0] exp_v;

    clk_out_seq #(.DIV_W(DW), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .lock(lock), .cfg_en(cfg_en), .cfg_div(cfg_div),
        .cfg_load(cfg_load), .oddr_d0(oddr_d0), .oddr_d1(oddr_d1), .ready(ready),
        .running(running), .upd_pending(upd_pending), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Waveform modelled as a position within a 2N-cycle period: high while pos < N.
    task automatic model(input bit r, input bit l, input bit e, input int dv, input bit ld);
        int nst;
        bit bnd, apl, fresh, on, hi;
        if (r) begin
            m_st = M_WAIT; m_sc = 0; m_nact = 0; m_npend = 0; m_pos = 0;
            m_pend = 0; m_lost = 0; exp_v = '0;
            return;
        end
        bnd = m_nact == 0 || m_pos == 2 * m_nact - 1;
        apl = m_pend && (m_st == M_WAIT || m_st == M_SETTLE || m_st == M_IDLE ||
                         ((m_st == M_RUN || m_st == M_STOP) && bnd));
        nst = m_st;
        fresh = 0;
        if (m_st == M_WAIT) begin
            if (l) begin nst = M_SETTLE; m_sc = 0; end
        end else if (m_st == M_SETTLE) begin
            if (!l) nst = M_WAIT;
            else begin
                m_sc++;
                if (m_sc == SC) nst = M_IDLE;
            end
        end else if (m_st == M_FAULT) begin
            if (!e) nst = M_WAIT;
        end else if (!l) begin
`ifdef CLK_OUT_SEQ_AUTORESTART_EN
            nst = M_WAIT;
`else
            nst = M_FAULT;
`endif
            m_lost = 1;
        end else if (m_st == M_IDLE) begin
            if (e) begin nst = M_RUN; fresh = 1; m_lost = 0; end
        end else if (m_st == M_RUN) begin
            if (!e) nst = bnd ? M_IDLE : M_STOP;
        end else if (bnd) nst = M_IDLE;
        if (apl) m_nact = m_npend;
        if (ld) begin m_npend = dv; m_pend = 1; end
        else if (apl) m_pend = 0;
        on = nst == M_RUN || nst == M_STOP;
        m_pos = on ? ((fresh || bnd) ? 0 : m_pos + 1) : 0;
        m_st = nst;
        hi = m_nact == 0 || m_pos < m_nact;
        exp_v = {on && hi, on && hi && m_nact != 0, nst == M_IDLE || on, on, m_pend, m_lost};
    endtask

    task automatic step(input string tag, input bit r, input bit l, input bit e, input int dv, input bit ld);
        logic [5:0] obs;
        rst = r; lock = l; cfg_en = e; cfg_div = DW'(dv); cfg_load = ld;
        model(r, l, e, dv, ld);
        @(posedge clk);
        #1;
        obs = {oddr_d0, oddr_d1, ready, running, upd_pending, lock_lost};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s t=%0t d0,d1,ready,running,upd_pending,lock_lost got=%b want=%b",
                   tag, $time, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1; lock = 0; cfg_en = 0; cfg_div = '0; cfg_load = 0;
        #1;
        repeat (3) step("reset", 1, 0, 0, 0, 0);
        repeat (10) step("pre_lock", 0, 0, 0, 0, 0);
        repeat (10) step("settle", 0, 1, 0, 0, 0);
        step("lock_glitch", 0, 0, 0, 0, 0);
        repeat (SC + 3) step("settle_restart", 0, 1, 0, 0, 0);
        step("load_div0", 0, 1, 0, 0, 1);
        repeat (3) step("idle", 0, 1, 0, 0, 0);
        repeat (8) step("pass_run", 0, 1, 1, 0, 0);
        repeat (3) step("pass_stop", 0, 1, 0, 0, 0);
        step("load_div3", 0, 1, 0, 3, 1);
        repeat (2) step("idle", 0, 1, 0, 0, 0);
        repeat (14) step("div3_run", 0, 1, 1, 0, 0);
        repeat (8) step("div3_stop", 0, 1, 0, 0, 0);
        step("load_div2", 0, 1, 0, 2, 1);
        repeat (2) step("idle", 0, 1, 0, 0, 0);
        repeat (9) step("div2_run", 0, 1, 1, 0, 0);
        step("load_div5", 0, 1, 1, 5, 1);
        repeat (14) step("upd_div5", 0, 1, 1, 0, 0);
        step("reload_div5", 0, 1, 1, 5, 1);
        step("reload_div7", 0, 1, 1, 7, 1);
        repeat (30) step("upd_div7", 0, 1, 1, 0, 0);
        step("load_div15", 0, 1, 1, 15, 1);
        repeat (70) step("div15_max", 0, 1, 1, 0, 0);
        repeat (2) step("lock_loss", 0, 0, 1, 0, 0);
        repeat (SC + 5) step("relock_en_held", 0, 1, 1, 0, 0);
        repeat (SC + 5) step("relock_en_low", 0, 1, 0, 0, 0);
        repeat (10) step("rerun", 0, 1, 1, 0, 0);
        r_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) r_en = !r_en;
            step("random", 0, $urandom_range(0, 299) != 0, r_en,
                 int'($urandom_range(0, 15)), $urandom_range(0, 11) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
